// File: rtl/nv_tieoff_chk.sv
// nv_tieoff_chk: filtered tie-off net checker with sticky fault status; optional fault-entry pulse under NV_TIEOFF_CHK_IRQ_EN.
module nv_tieoff_chk #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] EXP = '0,
  parameter int FILT = 4
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic [WIDTH-1:0] tie_in,
  input  logic             chk_en,
  input  logic             clr,
  output logic             err,
  output logic [WIDTH-1:0] err_bits,
  output logic [15:0]      mis_cnt,
  output logic             err_pulse
);
  typedef enum logic [1:0] {IDLE, ARMED, FILTER, FAULT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] tie_q;
  logic [3:0] flt_cnt, flt_n;
  logic mm, rec;
  assign mm = chk_en && (tie_q != EXP);
  assign rec = mm && (state != IDLE) && !clr;
  assign err = (state == FAULT);
  always_comb begin
    state_n = state;
    flt_n = flt_cnt;
    unique case (state)
      IDLE: if (chk_en) begin
        state_n = ARMED;
        flt_n = 4'd0;
      end
      ARMED: if (!chk_en) begin
        state_n = IDLE;
        flt_n = 4'd0;
      end else if (mm) begin
        state_n = (FILT == 1) ? FAULT : FILTER;
        flt_n = 4'd1;
      end
      FILTER: if (!chk_en) begin
        state_n = IDLE;
        flt_n = 4'd0;
      end else if (mm) begin
        flt_n = flt_cnt + 4'd1;
        state_n = (flt_n == 4'(FILT)) ? FAULT : FILTER;
      end else begin
        state_n = ARMED;
        flt_n = 4'd0;
      end
      FAULT: state_n = FAULT;
    endcase
    if (clr) begin
      state_n = IDLE;
      flt_n = 4'd0;
    end
  end
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state <= IDLE;
      tie_q <= EXP;
      flt_cnt <= 4'd0;
      err_bits <= '0;
      mis_cnt <= 16'd0;
    end else begin
      state <= state_n;
      tie_q <= tie_in;
      flt_cnt <= flt_n;
      if (clr) begin
        err_bits <= '0;
        mis_cnt <= 16'd0;
      end else if (rec) begin
        err_bits <= err_bits | (tie_q ^ EXP);
        mis_cnt <= mis_cnt + 16'(mis_cnt != 16'hFFFF);
      end
    end
  end
`ifdef NV_TIEOFF_CHK_IRQ_EN
  logic pulse_q;
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) pulse_q <= 1'b0;
    else pulse_q <= (state_n == FAULT) && (state != FAULT);
  end
  assign err_pulse = pulse_q;
`else
  assign err_pulse = 1'b0;
`endif
endmodule

// File: doc/nv_tieoff_chk.md
NV_TIEOFF_CHK -- requirements
Module: nv_tieoff_chk

Interface
REQ-001 The block SHALL use exactly one clock and one reset; the reset SHALL be synchronous and active-high.
REQ-002 Parameter WIDTH, default 8: number of monitored tie-off nets, legal range 1..32.
REQ-003 Parameter EXP, default 0 (WIDTH bits): expected constant value of the tie-off nets.
REQ-004 Parameter FILT, default 4: consecutive mismatching samples needed to declare a fault, legal range 1..15.
REQ-005 nvdla_core_clk  input  1  block clock; all state changes on its rising edge.
REQ-006 nvdla_core_rst  input  1  synchronous active-high reset.
REQ-007 tie_in  input  WIDTH  tie-off nets under check, driven by constant-source blackbox cells.
REQ-008 chk_en  input  1  checking enable.
REQ-009 clr  input  1  synchronous clear of fault and status.
REQ-010 err  output  1  sticky fault flag.
REQ-011 err_bits  output  WIDTH  sticky OR of mismatching bit positions.
REQ-012 mis_cnt  output  16  saturating count of mismatching samples.
REQ-013 err_pulse  output  1  one-cycle pulse on fault entry; see REQ-031 and REQ-032.

Function
REQ-014 tie_q SHALL register tie_in every cycle, unconditionally.
REQ-015 Mismatch mm SHALL equal chk_en AND (tie_q != EXP), evaluated combinationally.
REQ-016 The FSM SHALL have four states: IDLE, ARMED, FILTER and FAULT, held in a 2-bit register with a 4-bit consecutive-mismatch counter flt_cnt.
REQ-017 From IDLE, chk_en=1 SHALL move to ARMED, with flt_cnt=0.
REQ-018 From ARMED, mm=1 SHALL move to FILTER with flt_cnt=1; if FILT==1, ARMED SHALL move directly to FAULT instead.
REQ-019 In FILTER, mm=1 SHALL increment flt_cnt.
REQ-020 In FILTER, when flt_cnt+1==FILT the FSM SHALL enter FAULT.
REQ-021 In FILTER, mm=0 SHALL return to ARMED and zero flt_cnt.
REQ-022 In ARMED or FILTER, chk_en=0 SHALL move to IDLE and zero flt_cnt, taking priority over REQ-018 to REQ-021.
REQ-023 FAULT SHALL be held regardless of chk_en and tie_in until clr or reset.
REQ-024 err SHALL be 1 exactly when the state is FAULT, so it is registered and rises FILT rising edges after the edge that captured the first mismatching tie_q.
REQ-025 On each cycle with mm=1, in any state other than IDLE, err_bits SHALL OR in (tie_q ^ EXP).
REQ-026 On each cycle with mm=1, in any state other than IDLE, mis_cnt SHALL increment, saturating at 16'hFFFF with no wrap-around.
REQ-027 clr=1 SHALL force IDLE and zero err, err_bits, mis_cnt and flt_cnt on the next edge, with priority over all FSM transitions.
REQ-028 When clr and mm are both 1 in the same cycle, clr SHALL win and no count SHALL be recorded for that cycle.

Reset
REQ-029 On nvdla_core_rst=1 at a rising edge, the block SHALL set state=IDLE, tie_q=EXP, and flt_cnt, err, err_bits, mis_cnt and err_pulse all to 0.
REQ-030 Reset asserted mid-FILTER or mid-FAULT SHALL abort the operation with no residual status; reset SHALL take priority over clr.

Configuration
REQ-031 With macro NV_TIEOFF_CHK_IRQ_EN defined, err_pulse SHALL be a registered 1 for exactly one cycle, on the edge entering FAULT, and SHALL not repeat while FAULT persists.
REQ-032 With NV_TIEOFF_CHK_IRQ_EN undefined, err_pulse SHALL be constant 0, with no pulse register present; all other behaviour SHALL be identical.

Verification
REQ-033 The bench SHALL cover, with WIDTH=8, EXP=0, FILT=4: chk_en=1, tie_in=8'h01 held -> err=1 on the 4th edge after tie_q capture; err_bits=8'h01; mis_cnt increments every cycle.
REQ-034 The bench SHALL cover: tie_in=8'h80 for 3 cycles, then 8'h00 -> err stays 0; FSM returns to ARMED; mis_cnt=3; err_bits=8'h80.
REQ-035 The bench SHALL cover: in FAULT, drive chk_en=0 -> err stays 1; then clr=1 for one cycle -> err=0, mis_cnt=0, err_bits=0, state IDLE.
REQ-036 The bench SHALL cover: a mismatch held for 70000 cycles -> mis_cnt saturates at 16'hFFFF and does not wrap.
REQ-037 The bench SHALL cover, with NV_TIEOFF_CHK_IRQ_EN defined and FILT=1: a single mismatching sample -> err_pulse=1 for exactly one cycle, concurrent with err rising.
REQ-038 The bench SHALL cover: nvdla_core_rst=1 and clr=1 asserted together mid-FILTER -> all outputs 0 on the next edge, state IDLE.
